// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states, iteration count.
package hilo_pkg;

    localparam int unsigned W    = 32;
    localparam int unsigned ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Absolute value for signed ops, pass-through for unsigned ones.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic isSigned);
        return (isSigned && x[W-1]) ? W'(-x) : x;
    endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Execute/Writeback-side signal bundle of the HI/LO multiply/divide unit.
interface hilo_muldiv_if;
    import hilo_pkg::*;

    logic         startE;
    logic [1:0]   opE;
    logic [W-1:0] srcaE;
    logic [W-1:0] srcbE;
    logic         cancel;
    logic         wbweW;
    logic         wbselW;
    logic [W-1:0] wbdataW;
    logic         stallE;
    logic         busy;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    modport master (
        output startE, opE, srcaE, srcbE, cancel, wbweW, wbselW, wbdataW,
        input  stallE, busy, hi_o, lo_o
    );

    modport slave (
        input  startE, opE, srcaE, srcbE, cancel, wbweW, wbselW, wbdataW,
        output stallE, busy, hi_o, lo_o
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step on the {remainder, quotient} accumulator.
module div_step
    import hilo_pkg::*;
(
    input  logic [2*W-1:0] accIn,
    input  logic [W-1:0]   divisor,
    output logic [2*W-1:0] accOut
);
    logic [W:0]   partial;
    logic [W-1:0] diff;

    // 33-bit partial remainder after shifting in the next dividend bit
    assign partial = accIn[2*W-1:W-1];
    assign diff    = partial[W-1:0] - divisor;

    always_comb begin
        accOut = {partial[W-1:0], accIn[W-2:0], 1'b0};
        if (partial >= {1'b0, divisor}) begin
            accOut = {diff, accIn[W-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with the HI/LO register pair and MTHI/MTLO port.
// Build option: MUL_ITERATIVE_EN selects a 32-step shift-add multiply instead of a combinational one.
module hilo_muldiv
    import hilo_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    hilo_muldiv_if.slave  bus
);
    state_t         state, stateNext;
    logic [4:0]     cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   opnd;
    logic           isMul, negLo, negHi;
    logic [W-1:0]   hiReg, loReg;

    logic           load, commit;
    logic           opSigned, opDiv;
    logic [W-1:0]   magA, magB;
    logic [2*W-1:0] divNext, stepNext, product, prodFixed;
    logic [W-1:0]   hiNext, loNext;

    assign opSigned = (bus.opE == OP_MULT) || (bus.opE == OP_DIV);
    assign opDiv    = (bus.opE == OP_DIV)  || (bus.opE == OP_DIVU);
    assign magA     = magnitude(bus.srcaE, opSigned);
    assign magB     = magnitude(bus.srcbE, opSigned);

    div_step uDivStep (
        .accIn   (acc),
        .divisor (opnd),
        .accOut  (divNext)
    );

`ifdef MUL_ITERATIVE_EN
    logic [W:0]     mulSum;
    logic [2*W-1:0] mulNext;

    // Shift-add: conditionally add multiplicand to the upper half, then shift right
    assign mulSum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    assign mulNext  = {mulSum, acc[W-1:1]};
    assign stepNext = isMul ? mulNext : divNext;
    assign product  = acc;
`else
    assign stepNext = divNext;
    assign product  = {{W{1'b0}}, acc[W-1:0]} * {{W{1'b0}}, opnd};
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and control strobes
    always_comb begin
        stateNext = state;
        load      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.startE && !bus.cancel) begin
                    load = 1'b1;
`ifdef MUL_ITERATIVE_EN
                    stateNext = RUN;
`else
                    stateNext = opDiv ? RUN : FIN;
`endif
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    stateNext = IDLE;
                end else if (cnt == 5'(ITER - 1)) begin
                    stateNext = FIN;
                end
            end
            FIN: begin
                stateNext = IDLE;
                commit    = !bus.cancel;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Sign correction of the finished result
    always_comb begin
        prodFixed = negLo ? -product : product;
        hiNext    = prodFixed[2*W-1:W];
        loNext    = prodFixed[W-1:0];
        if (!isMul) begin
            loNext = negLo ? -acc[W-1:0]     : acc[W-1:0];
            hiNext = negHi ? -acc[2*W-1:W]   : acc[2*W-1:W];
        end
    end

    // Operand latch and iteration datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            isMul <= 1'b0;
            negLo <= 1'b0;
            negHi <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            acc   <= {{W{1'b0}}, opDiv ? magA : magB};
            opnd  <= opDiv ? magB : magA;
            isMul <= !opDiv;
            negLo <= opSigned && (bus.srcaE[W-1] ^ bus.srcbE[W-1]);
            negHi <= opSigned && bus.srcaE[W-1];
        end else if (state == RUN) begin
            cnt   <= cnt + 5'd1;
            acc   <= stepNext;
        end
    end

    // HI/LO: the Execute commit overrides a same-edge Writeback write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hiReg <= '0;
            loReg <= '0;
        end else if (commit) begin
            hiReg <= hiNext;
            loReg <= loNext;
        end else if (bus.wbweW) begin
            if (bus.wbselW) begin
                hiReg <= bus.wbdataW;
            end else begin
                loReg <= bus.wbdataW;
            end
        end
    end

    assign bus.stallE = !bus.cancel && ((bus.startE && state == IDLE) || state == RUN);
    assign bus.busy   = (state != IDLE);
    assign bus.hi_o   = hiReg;
    assign bus.lo_o   = loReg;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized bench for hilo_muldiv against an arithmetic HI/LO reference model.
module tb_hilo_muldiv;
    import hilo_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_muldiv_if bus();

    hilo_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef MUL_ITERATIVE_EN
    localparam int MUL_STALL = 33;
`else
    localparam int MUL_STALL = 1;
`endif
    localparam int DIV_STALL = 33;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [31:0] hiM = 32'h0;
    logic [31:0] loM = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result {HI, LO} computed directly from the instruction semantics
    function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint p;
        int     sa, sb, q, r;
        sa = a;
        sb = b;
        case (op)
            OP_MULT: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            OP_MULTU: return {32'h0, a} * {32'h0, b};
            OP_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'h0) return {a, (sa >= 0) ? 32'hFFFFFFFF : 32'h00000001};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
        endcase
    endfunction

    function automatic int expStall(input logic [1:0] op);
        return (op == OP_DIV || op == OP_DIVU) ? DIV_STALL : MUL_STALL;
    endfunction

    task automatic checkRegs(input string tag);
        check({tag, ".hi"}, 64'(bus.hi_o), 64'(hiM));
        check({tag, ".lo"}, 64'(bus.lo_o), 64'(loM));
    endtask

    // Issue one op; optionally place a Writeback write on the commit edge
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wbwe, input logic wbsel, input logic [31:0] wbdata);
        int          stalls;
        logic [63:0] exp;
        stalls     = 0;
        bus.opE    = op;
        bus.srcaE  = a;
        bus.srcbE  = b;
        bus.startE = 1'b1;
        #1;
        while (bus.stallE && stalls < 100) begin
            stalls++;
            @(posedge clk);
            #1 bus.startE = 1'b0;
            #1;
        end
        bus.startE = 1'b0;
        check("stallCycles", 64'(stalls), 64'(expStall(op)));
        check("busyInFin", 64'(bus.busy), 64'd1);
        bus.wbweW   = wbwe;
        bus.wbselW  = wbsel;
        bus.wbdataW = wbdata;
        @(posedge clk);
        #1 bus.wbweW = 1'b0;
        exp = refResult(op, a, b);
        hiM = exp[63:32];
        loM = exp[31:0];
        checkRegs("result");
        check("busyAfter", 64'(bus.busy), 64'd0);
    endtask

    task automatic wbWrite(input logic sel, input logic [31:0] data);
        bus.wbweW   = 1'b1;
        bus.wbselW  = sel;
        bus.wbdataW = data;
        @(posedge clk);
        #1 bus.wbweW = 1'b0;
        if (sel) hiM = data;
        else     loM = data;
        checkRegs("mtHiLo");
    endtask

    task automatic cancelDiv(input logic [31:0] a, input logic [31:0] b, input int k);
        bus.opE    = OP_DIVU;
        bus.srcaE  = a;
        bus.srcbE  = b;
        bus.startE = 1'b1;
        @(posedge clk);
        #1 bus.startE = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
        bus.cancel = 1'b1;
        #1 check("cancelStall", 64'(bus.stallE), 64'd0);
        @(posedge clk);
        #1 bus.cancel = 1'b0;
        #1 check("cancelBusy", 64'(bus.busy), 64'd0);
        checkRegs("cancel");
    endtask

    task automatic resetMidDiv(input logic [31:0] a, input logic [31:0] b, input int k);
        bus.opE    = OP_DIVU;
        bus.srcaE  = a;
        bus.srcbE  = b;
        bus.startE = 1'b1;
        @(posedge clk);
        #1 bus.startE = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        hiM = 32'h0;
        loM = 32'h0;
        checkRegs("midReset");
        check("midResetBusy", 64'(bus.busy), 64'd0);
        check("midResetStall", 64'(bus.stallE), 64'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        bus.startE  = 1'b0;
        bus.opE     = 2'b00;
        bus.srcaE   = 32'h0;
        bus.srcbE   = 32'h0;
        bus.cancel  = 1'b0;
        bus.wbweW   = 1'b0;
        bus.wbselW  = 1'b0;
        bus.wbdataW = 32'h0;
        rst = 1'b0;
        #12;
        checkRegs("reset");
        check("resetBusy", 64'(bus.busy), 64'd0);
        check("resetStall", 64'(bus.stallE), 64'd0);
        #5 rst = 1'b1;
        @(posedge clk);
        #1;

        runOp(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'h0);
        runOp(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'h0);
        runOp(OP_MULT, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 32'h0);
        resetMidDiv(32'd1000, 32'd3, 10);
        runOp(OP_DIVU, 32'd9, 32'd3, 1'b1, 1'b0, 32'h1234);
        wbWrite(1'b1, 32'hABCD);
        runOp(OP_DIV, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
        cancelDiv(32'd50, 32'd5, 5);
        runOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);
        runOp(OP_DIV, 32'h80000000, 32'h0, 1'b0, 1'b0, 32'h0);
        runOp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'($urandom_range(0, 255));
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            runOp(op, a, b, ($urandom_range(0, 3) == 0), 1'($urandom), $urandom);
            if ($urandom_range(0, 2) == 0) wbWrite(1'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
